// File: rtl/functions_tasks_pkg.sv
// ----------------------------------------------------------------------------
// functions_tasks_pkg
// Small combinational helpers shared by the game logic.
//   abs_diff10(a, b) : unsigned |a - b| of two 10-bit screen coordinates,
//                      computed as larger minus smaller so it never wraps.
// ----------------------------------------------------------------------------
package functions_tasks_pkg;

    function automatic logic [9:0] abs_diff10(input logic [9:0] a,
                                              input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage : functions_tasks_pkg

// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the Tom-and-Jerry round sequencer.
//   - game_state_t : state encoding, also driven out on game_state for the
//                    overlay renderer
//   - RESPAWN_CYCLES : cycles the movement controllers are held in reset
//   - DEF_* : default timing constants for a 65 MHz pixel clock
// Optional feature macro: GAME_PAUSE_EN (adds the PAUSED state, encoding 7).
// ----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESPAWN   = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_PLAY      = 3'd3,
        ST_CAUGHT    = 3'd4,
        ST_TIMEOUT   = 3'd5,
        ST_GAME_OVER = 3'd6
`ifdef GAME_PAUSE_EN
        ,
        ST_PAUSED    = 3'd7
`endif
    } game_state_t;

    localparam int RESPAWN_CYCLES        = 4;

    localparam int DEF_SEC_TICKS         = 65_000_000;
    localparam int DEF_COUNTDOWN_SECONDS = 3;
    localparam int DEF_ROUND_SECONDS     = 60;
    localparam int DEF_HOLD_SECONDS      = 2;
    localparam int DEF_CATCH_DIST        = 16;
    localparam int DEF_WIN_SCORE         = 5;

endpackage : game_pkg

// File: rtl/game_round_ctrl_sec_tick_gen.sv
// ----------------------------------------------------------------------------
// sec_tick_gen
// One-second prescaler for the round sequencer.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-low reset
//   clr      in  force the count to 0 (takes priority over everything)
//   run      in  count this cycle
//   hold     in  (GAME_PAUSE_EN only) freeze the count even while run=1
//   sec_tick out 1 in the cycle the count equals SEC_TICKS-1 while counting
// ----------------------------------------------------------------------------
module sec_tick_gen #(
    parameter int SEC_TICKS = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
`ifdef GAME_PAUSE_EN
    input  logic hold,
`endif
    output logic sec_tick
);

    localparam int CW = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SEC_TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          active;

`ifdef GAME_PAUSE_EN
    assign active = run & ~hold;
`else
    assign active = run;
`endif

    // Tick is taken from the registered count so it can feed the state
    // machine's next-state logic without a combinational loop through clr.
    assign sec_tick = active && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (active) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : sec_tick_gen

// File: rtl/game_round_ctrl.sv
// ----------------------------------------------------------------------------
// game_round_ctrl
// Round sequencer for the Tom-and-Jerry game. Gates both players' controls,
// holds the movement controllers in reset while respawning, runs the
// countdown / round / hold timers, detects a catch, keeps scores and ends
// the game when either player reaches WIN_SCORE.
// Ports:
//   clk, rst (sync, active-low), start (1-cycle start/restart pulse)
//   tom_*_in, jerry_*_in      raw player controls
//   tom_x/y, jerry_x/y        10-bit top-left coordinates
//   tom_*, jerry_*            gated controls (follow raw inputs only in PLAY)
//   move_rst                  active-high reset to both movement controllers
//   game_state                encoded state for the overlay renderer
//   time_left                 seconds remaining in COUNTDOWN/PLAY
//   score_tom, score_jerry    saturating 4-bit scores
//   round_end                 1-cycle pulse on entry to CAUGHT or TIMEOUT
//   pause                     (GAME_PAUSE_EN only) 1-cycle pause toggle
// Optional feature macro: GAME_PAUSE_EN.
// All outputs are registered.
// ----------------------------------------------------------------------------
module game_round_ctrl
    import game_pkg::*;
    import functions_tasks_pkg::*;
#(
    parameter int SEC_TICKS         = DEF_SEC_TICKS,
    parameter int COUNTDOWN_SECONDS = DEF_COUNTDOWN_SECONDS,
    parameter int ROUND_SECONDS     = DEF_ROUND_SECONDS,
    parameter int HOLD_SECONDS      = DEF_HOLD_SECONDS,
    parameter int CATCH_DIST        = DEF_CATCH_DIST,
    parameter int WIN_SCORE         = DEF_WIN_SCORE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef GAME_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       tom_left_in,
    input  logic       tom_right_in,
    input  logic       tom_jump_in,
    input  logic       jerry_left_in,
    input  logic       jerry_right_in,
    input  logic       jerry_jump_in,
    input  logic [9:0] tom_x,
    input  logic [9:0] tom_y,
    input  logic [9:0] jerry_x,
    input  logic [9:0] jerry_y,
    output logic       tom_left,
    output logic       tom_right,
    output logic       tom_jump,
    output logic       jerry_left,
    output logic       jerry_right,
    output logic       jerry_jump,
    output logic       move_rst,
    output logic [2:0] game_state,
    output logic [6:0] time_left,
    output logic [3:0] score_tom,
    output logic [3:0] score_jerry,
    output logic       round_end
);

    localparam int RSP_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
    localparam logic [RSP_W-1:0] RSP_LAST  = RSP_W'(RESPAWN_CYCLES - 1);
    localparam logic [10:0]      CATCH_LIM = 11'(CATCH_DIST);
    localparam logic [6:0]       HOLD_LIM  = 7'(HOLD_SECONDS);
    localparam logic [3:0]       WIN_LIM   = 4'(WIN_SCORE);

    game_state_t      state_q, state_d;
    logic [6:0]       time_left_q, time_left_d;
    logic [3:0]       score_tom_q, score_tom_d;
    logic [3:0]       score_jerry_q, score_jerry_d;
    logic             round_end_q, round_end_d;
    logic             move_rst_q, move_rst_d;
    logic [5:0]       ctrl_q, ctrl_d;
    logic [6:0]       hold_q, hold_d;
    logic [RSP_W-1:0] rsp_q, rsp_d;
    logic             catch_q, catch_d;

    logic             sec_tick;
    logic             presc_clr;
    logic             presc_run;
    logic             win;
    logic [6:0]       hold_inc;

    // Catch compare is registered: coordinates sampled at edge N move the
    // state to CAUGHT at edge N+1.
    assign catch_d = ({1'b0, abs_diff10(tom_x, jerry_x)} < CATCH_LIM) &&
                     ({1'b0, abs_diff10(tom_y, jerry_y)} < CATCH_LIM);

    assign presc_run = (state_q == ST_COUNTDOWN) || (state_q == ST_PLAY) ||
                       (state_q == ST_CAUGHT)    || (state_q == ST_TIMEOUT);

`ifdef GAME_PAUSE_EN
    // PLAY <-> PAUSED keeps the prescaler value so the second resumes where
    // it left off; every other state change restarts it.
    assign presc_clr = (state_d != state_q) &&
                       !((state_q == ST_PLAY)   && (state_d == ST_PAUSED)) &&
                       !((state_q == ST_PAUSED) && (state_d == ST_PLAY));
`else
    assign presc_clr = (state_d != state_q);
`endif

    sec_tick_gen #(
        .SEC_TICKS (SEC_TICKS)
    ) u_sec_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (presc_clr),
        .run      (presc_run),
`ifdef GAME_PAUSE_EN
        .hold     (state_q == ST_PAUSED),
`endif
        .sec_tick (sec_tick)
    );

    // Scores are already updated on entry to CAUGHT/TIMEOUT, so the hold
    // exit can look at the registered values.
    assign win      = (score_tom_q >= WIN_LIM) || (score_jerry_q >= WIN_LIM);
    assign hold_inc = hold_q + 7'd1;

    always_comb begin
        state_d       = state_q;
        time_left_d   = time_left_q;
        score_tom_d   = score_tom_q;
        score_jerry_d = score_jerry_q;
        round_end_d   = 1'b0;
        hold_d        = hold_q;
        rsp_d         = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RESPAWN;
                end
            end

            ST_RESPAWN: begin
                rsp_d = rsp_q + 1'b1;
                if (rsp_q == RSP_LAST) begin
                    rsp_d       = '0;
                    state_d     = ST_COUNTDOWN;
                    time_left_d = 7'(COUNTDOWN_SECONDS);
                end
            end

            ST_COUNTDOWN: begin
                if (sec_tick) begin
                    if (time_left_q > 7'd1) begin
                        time_left_d = time_left_q - 7'd1;
                    end else begin
                        state_d     = ST_PLAY;
                        time_left_d = 7'(ROUND_SECONDS);
                    end
                end
            end

            ST_PLAY: begin
                // Catch has priority over the final second: Jerry is not
                // scored when both happen together.
                if (catch_q) begin
                    state_d     = ST_CAUGHT;
                    score_tom_d = (score_tom_q == 4'hF) ? 4'hF : score_tom_q + 4'd1;
                    round_end_d = 1'b1;
                    hold_d      = '0;
                end else if (sec_tick && (time_left_q <= 7'd1)) begin
                    state_d       = ST_TIMEOUT;
                    time_left_d   = '0;
                    score_jerry_d = (score_jerry_q == 4'hF) ? 4'hF : score_jerry_q + 4'd1;
                    round_end_d   = 1'b1;
                    hold_d        = '0;
                end else begin
                    if (sec_tick) begin
                        time_left_d = time_left_q - 7'd1;
                    end
`ifdef GAME_PAUSE_EN
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end
`endif
                end
            end

            ST_CAUGHT, ST_TIMEOUT: begin
                if (sec_tick) begin
                    hold_d = hold_inc;
                    if (hold_inc >= HOLD_LIM) begin
                        hold_d  = '0;
                        state_d = win ? ST_GAME_OVER : ST_RESPAWN;
                    end
                end
            end

            ST_GAME_OVER: begin
                if (start) begin
                    state_d       = ST_RESPAWN;
                    score_tom_d   = '0;
                    score_jerry_d = '0;
                end
            end

`ifdef GAME_PAUSE_EN
            ST_PAUSED: begin
                if (pause) begin
                    state_d = ST_PLAY;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they change on the
        // same edge as game_state.
        move_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESPAWN);
        ctrl_d     = (state_d == ST_PLAY) ?
                     {tom_left_in, tom_right_in, tom_jump_in,
                      jerry_left_in, jerry_right_in, jerry_jump_in} : 6'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            time_left_q   <= '0;
            score_tom_q   <= '0;
            score_jerry_q <= '0;
            round_end_q   <= 1'b0;
            move_rst_q    <= 1'b1;
            ctrl_q        <= '0;
            hold_q        <= '0;
            rsp_q         <= '0;
            catch_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            time_left_q   <= time_left_d;
            score_tom_q   <= score_tom_d;
            score_jerry_q <= score_jerry_d;
            round_end_q   <= round_end_d;
            move_rst_q    <= move_rst_d;
            ctrl_q        <= ctrl_d;
            hold_q        <= hold_d;
            rsp_q         <= rsp_d;
            catch_q       <= catch_d;
        end
    end

    assign game_state  = 3'(state_q);
    assign time_left   = time_left_q;
    assign score_tom   = score_tom_q;
    assign score_jerry = score_jerry_q;
    assign round_end   = round_end_q;
    assign move_rst    = move_rst_q;
    assign tom_left    = ctrl_q[5];
    assign tom_right   = ctrl_q[4];
    assign tom_jump    = ctrl_q[3];
    assign jerry_left  = ctrl_q[2];
    assign jerry_right = ctrl_q[1];
    assign jerry_jump  = ctrl_q[0];

endmodule : game_round_ctrl

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the Tom-and-Jerry game. Sits between the keyboard/UART input decoders and the two player movement controllers.
- Gates each player's left/right/jump, and respawns both players by holding their active-high move reset.
- Runs countdown and round timers, detects a catch from both players' coordinates, keeps per-player scores and declares game over.

Parameters:
- SEC_TICKS, 65_000_000, clk cycles per one-second tick (65 MHz pixel clock).
- COUNTDOWN_SECONDS, 3, pre-round countdown length.
- ROUND_SECONDS, 60, round duration; must be ≤127.
- HOLD_SECONDS, 2, freeze time after a catch or timeout.
- CATCH_DIST, 16, catch when both |dx| and |dy| are strictly below this (pixels).
- WIN_SCORE, 5, score that ends the game; must be ≤15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle start/restart pulse
- tom_left_in, tom_right_in, tom_jump_in  in  1 each  raw Tom controls
- jerry_left_in, jerry_right_in, jerry_jump_in  in  1 each  raw Jerry controls
- tom_x, tom_y, jerry_x, jerry_y  in  10 each  top-left coordinates from the movement controllers
- tom_left, tom_right, tom_jump, jerry_left, jerry_right, jerry_jump  out  1 each  gated controls
- move_rst  out  1  active-high reset to both movement controllers
- game_state  out  3  encoded state, for the overlay renderer
- time_left  out  7  seconds remaining in COUNTDOWN/PLAY
- score_tom, score_jerry  out  4 each  scores
- round_end  out  1  one-cycle pulse on entry to CAUGHT or TIMEOUT

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge):
  - state=IDLE, move_rst=1, gated controls=0, time_left=0, scores=0, round_end=0, prescaler=0.
  - Reset mid-round aborts immediately; no score change is committed.
- Gated controls equal the raw inputs (one cycle later) only in PLAY; they are 0 in every other state.
- Prescaler:
  - Counts 0..SEC_TICKS-1 in COUNTDOWN, PLAY, CAUGHT and TIMEOUT.
  - Cleared on every state change.
  - sec_tick=1 in the cycle the count equals SEC_TICKS-1.
- States (game_state encoding):
  - IDLE(0): move_rst=1. start → RESPAWN.
  - RESPAWN(1): move_rst=1 for exactly 4 cycles. Then → COUNTDOWN with time_left=COUNTDOWN_SECONDS.
  - COUNTDOWN(2): move_rst=0, so the controllers spawn at their fixed positions.
    - sec_tick with time_left>1: decrement.
    - sec_tick with time_left==1: → PLAY, time_left=ROUND_SECONDS.
  - PLAY(3): catch = abs(tom_x-jerry_x)<CATCH_DIST && abs(tom_y-jerry_y)<CATCH_DIST.
    - Differences are unsigned 10-bit, computed as larger minus smaller.
    - catch → CAUGHT next edge; score_tom+1 (saturate 15); round_end=1.
    - Else sec_tick with time_left==1 → TIMEOUT, time_left=0, score_jerry+1 (saturate), round_end=1.
    - Else sec_tick: decrement time_left.
    - Catch and final tick in the same cycle: catch wins; Jerry is not scored.
  - CAUGHT(4) / TIMEOUT(5): hold counter starts at 0 on entry and increments on each sec_tick.
    - When the counter reaches HOLD_SECONDS: any score ≥ WIN_SCORE → GAME_OVER, else → RESPAWN.
  - GAME_OVER(6): scores and time_left frozen; move_rst=0, players stay visible. start → clear scores → RESPAWN.
  - Encoding 7 is illegal → IDLE.
- start is ignored in every state other than IDLE and GAME_OVER.
- Latency: catch condition at clk edge N → game_state=4, round_end=1 and gated controls=0 visible after edge N+1.

Optional Feature:
- GAME_PAUSE_EN defined:
  - Adds input pause (1-cycle pulse) and state PAUSED(7).
  - A pause pulse in PLAY → PAUSED. The prescaler holds its value (not cleared); time_left is frozen; controls are gated to 0; move_rst=0.
  - A pause pulse in PAUSED → PLAY, prescaler resuming from its held value.
  - rst or start while PAUSED has no special handling beyond reset rules; start is ignored.
- Undefined: no pause port; encoding 7 is illegal → IDLE.

Decomposition:
- game_pkg: game_state_t enum, RESPAWN_CYCLES=4, and the default timing constants.
- One sub-module, sec_tick_gen:
  - Prescaler with clear and hold (hold only under GAME_PAUSE_EN).
  - Outputs a single-cycle sec_tick.
- Catch distance compare stays inline as a function in functions_tasks_pkg (abs_diff10).

Test Plan:
All scenarios use SEC_TICKS=10, COUNTDOWN_SECONDS=3, ROUND_SECONDS=5, HOLD_SECONDS=2, WIN_SCORE=2.
1. Reset then start pulse → move_rst=1 for 4 cycles, then COUNTDOWN time_left 3,2,1 at 10-cycle steps → PLAY, time_left=5.
2. In PLAY: tom=(100,600), jerry=(115,610) → next edge CAUGHT, score_tom=1, round_end pulses once, controls=0. Repeat with jerry_x=116 → no catch.
3. No catch for 5 s → TIMEOUT, score_jerry=1, time_left=0; after 20 cycles → RESPAWN.
4. Catch coincident with final sec_tick → CAUGHT, score_tom+1, score_jerry unchanged.
5. Two catches → GAME_OVER after hold; start → scores 0, RESPAWN; start pulsed during PLAY ignored.
6. rst=0 asserted mid-PLAY for one cycle → IDLE, scores 0, move_rst=1. With GAME_PAUSE_EN: pause at time_left=4 for 50 cycles → time_left stays 4 and resumes.
